// File: rtl/threshold_sequencer.sv
// Threshold sequencer: binarizes NUM_WORDS memory words in place; read-to-write latency 2, done N+3 cycles after start.
// No backpressure (one word per cycle, abort flushes); define THRESH_COUNT_EN to add the fg_count foreground pixel counter.
module threshold_sequencer #(
  parameter int unsigned NUM_WORDS = 76800,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        thresh,
  output logic [ADDR_W-1:0] mem_addr_a,
  input  logic [31:0]       mem_dout_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [31:0]       mem_din_b,
  output logic              mem_we_b,
  output logic              busy,
  output logic              done
`ifdef THRESH_COUNT_EN
  ,
  output logic [18:0]       fg_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic [7:0]        thr_q, thr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_dat_q, wr_dat_d;
  logic              done_q, done_d;
  logic              abort_hit;
  logic [31:0]       bin_word;
  logic [2:0]        pix_hits;

  // Each byte of the word currently on the read port is compared against the latched threshold.
  always_comb begin
    bin_word = '0;
    pix_hits = '0;
    for (int i = 0; i < 4; i++) begin
      if (mem_dout_a[8*i +: 8] >= thr_q) begin
        bin_word[8*i +: 8] = 8'hFF;
        pix_hits           = pix_hits + 3'd1;
      end
    end
  end

  assign abort_hit = abort && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    thr_d      = thr_q;
    rd_vld_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_dat_d   = wr_dat_q;
    done_d     = 1'b0;
    mem_addr_a = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          thr_d   = thresh;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mem_addr_a = cnt_q;
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rd_vld_d  = 1'b1;
          rd_addr_d = cnt_q;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            drain_d = 1'b0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end else if (drain_q) begin
          drain_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Data for the address issued last cycle is on mem_dout_a now; register it as the write.
    if (rd_vld_q && !abort_hit) begin
      we_d      = 1'b1;
      wr_addr_d = rd_addr_q;
      wr_dat_d  = bin_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      thr_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      thr_q     <= thr_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
      done_q    <= done_d;
    end
  end

  assign mem_we_b   = we_q;
  assign mem_addr_b = wr_addr_q;
  assign mem_din_b  = wr_dat_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

`ifdef THRESH_COUNT_EN
  logic [18:0] fg_q, fg_d;

  // Counted when the write is registered, so an abort keeps exactly the pixels that reached memory.
  always_comb begin
    fg_d = fg_q;
    if ((state_q == S_IDLE) && start) begin
      fg_d = '0;
    end else if (we_d) begin
      fg_d = fg_q + 19'(pix_hits);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_q <= '0;
    end else begin
      fg_q <= fg_d;
    end
  end

  assign fg_count = fg_q;
`endif

endmodule
